// File: rtl/lock_ctrl_fsm.sv
// Lock controller: stores a password, checks entered key sequences, counts misses, enforces lockout.
// Optional AUTO_RELOCK_EN: UNLOCKED falls back to LOCKED after UNLOCK_CYCLES idle cycles.
module lock_ctrl_fsm #(
    parameter int unsigned NKEYS          = 4,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned LOCKOUT_CYCLES = 50000000,
    parameter int unsigned UNLOCK_CYCLES  = 250000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2*NKEYS-1:0] seq_i,
    input  logic               seq_valid_i,
    input  logic               mode_set_i,
    input  logic               relock_i,
    output logic               entry_en_o,
    output logic               entry_clr_o,
    output logic               unlocked_o,
    output logic               alarm_o,
    output logic [3:0]         fail_cnt_o,
    output logic [2:0]         state_code_o
);

    localparam int unsigned SW    = 2 * NKEYS;
    localparam int unsigned MAXC  = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int unsigned TW    = $clog2(MAXC + 1);

    // Three-bit encoding leaves spare codes that are recovered to INIT.
    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_LOCKED   = 3'd1,
        S_UNLOCKED = 3'd2,
        S_LOCKOUT  = 3'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   pw_q, pw_d;
    logic            pw_valid_q, pw_valid_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      fail_q, fail_d;
    logic            clr_d;
    logic            entry_en_d;
    logic            match_s;

    assign match_s = pw_valid_q && (seq_i == pw_q);

    // Next-state, password, timer and miss-counter decode.
    always_comb begin
        state_d    = state_q;
        pw_d       = pw_q;
        pw_valid_d = pw_valid_q;
        timer_d    = timer_q;
        fail_d     = fail_q;
        clr_d      = 1'b0;
        case (state_q)
            S_INIT: begin
                if (seq_valid_i) begin
                    pw_d       = seq_i;
                    pw_valid_d = 1'b1;
                    state_d    = S_LOCKED;
                    timer_d    = {TW{1'b0}};
                    clr_d      = 1'b1;
                end else begin
                    state_d = S_INIT;
                end
            end
            S_LOCKED: begin
                if (seq_valid_i) begin
                    clr_d   = 1'b1;
                    timer_d = {TW{1'b0}};
                    if (match_s) begin
                        state_d = S_UNLOCKED;
                        fail_d  = 4'd0;
                    end else if ((fail_q + 4'd1) >= 4'(MAX_FAIL)) begin
                        state_d = S_LOCKOUT;
                        fail_d  = 4'(MAX_FAIL);
                    end else begin
                        fail_d  = fail_q + 4'd1;
                    end
                end else begin
                    state_d = S_LOCKED;
                end
            end
            S_UNLOCKED: begin
                if (relock_i) begin
                    // Relock has priority; a coincident sequence is consumed but discarded.
                    state_d = S_LOCKED;
                    timer_d = {TW{1'b0}};
                    clr_d   = seq_valid_i;
                end else if (seq_valid_i) begin
                    clr_d = 1'b1;
                    if (mode_set_i) begin
                        pw_d    = seq_i;
                        timer_d = {TW{1'b0}};
                    end else begin
                        pw_d    = pw_q;
                    end
                end else begin
`ifdef AUTO_RELOCK_EN
                    if (timer_q >= TW'(UNLOCK_CYCLES - 1)) begin
                        state_d = S_LOCKED;
                        timer_d = {TW{1'b0}};
                    end else begin
                        timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
                    end
`else
                    state_d = S_UNLOCKED;
`endif
                end
            end
            S_LOCKOUT: begin
                if (timer_q >= TW'(LOCKOUT_CYCLES - 1)) begin
                    state_d = S_LOCKED;
                    fail_d  = 4'd0;
                    timer_d = {TW{1'b0}};
                end else begin
                    timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = S_INIT;
                fail_d  = 4'd0;
                timer_d = {TW{1'b0}};
            end
        endcase
    end

    // Moore decode of the next state so outputs change on the same edge as state.
    always_comb begin
        case (state_d)
            S_INIT:     entry_en_d = 1'b1;
            S_LOCKED:   entry_en_d = 1'b1;
            S_UNLOCKED: entry_en_d = mode_set_i;
            S_LOCKOUT:  entry_en_d = 1'b0;
            default:    entry_en_d = 1'b1;
        endcase
    end

    // State, storage and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_INIT;
            pw_q         <= {SW{1'b0}};
            pw_valid_q   <= 1'b0;
            timer_q      <= {TW{1'b0}};
            fail_q       <= 4'd0;
            entry_en_o   <= 1'b0;
            entry_clr_o  <= 1'b0;
            unlocked_o   <= 1'b0;
            alarm_o      <= 1'b0;
            state_code_o <= 3'd0;
        end else begin
            state_q      <= state_d;
            pw_q         <= pw_d;
            pw_valid_q   <= pw_valid_d;
            timer_q      <= timer_d;
            fail_q       <= fail_d;
            entry_en_o   <= entry_en_d;
            entry_clr_o  <= clr_d;
            unlocked_o   <= (state_d == S_UNLOCKED);
            alarm_o      <= (state_d == S_LOCKOUT);
            state_code_o <= state_d;
        end
    end

    assign fail_cnt_o = fail_q;

endmodule

// File: tb/tb_lock_ctrl_fsm.sv
// Directed bench for lock_ctrl_fsm with short lockout/unlock timings.
module tb_lock_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] seq;
    logic       seq_valid;
    logic       mode_set;
    logic       relock;
    logic       entry_en;
    logic       entry_clr;
    logic       unlocked;
    logic       alarm;
    logic [3:0] fail_cnt;
    logic [2:0] state_code;

    int tests = 0;
    int fails = 0;

    lock_ctrl_fsm #(
        .NKEYS(4), .MAX_FAIL(3), .LOCKOUT_CYCLES(8), .UNLOCK_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .seq_i(seq), .seq_valid_i(seq_valid),
        .mode_set_i(mode_set), .relock_i(relock), .entry_en_o(entry_en),
        .entry_clr_o(entry_clr), .unlocked_o(unlocked), .alarm_o(alarm),
        .fail_cnt_o(fail_cnt), .state_code_o(state_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sequence pulse (optionally with relock) across a single edge.
    task automatic pulse(input logic [7:0] s, input logic sv, input logic rl);
        seq       = s;
        seq_valid = sv;
        relock    = rl;
        tick();
        seq_valid = 1'b0;
        relock    = 1'b0;
    endtask

    int n_alarm;
    int n_clr;

    initial begin
        rst_n = 1'b0; seq = 8'h00; seq_valid = 1'b0; mode_set = 1'b0; relock = 1'b0;
        repeat (3) tick();
        chk("rst_state", {29'd0, state_code}, 32'd0);
        chk("rst_outs", {28'd0, entry_en, entry_clr, unlocked, alarm}, 32'd0);
        chk("rst_fail", {28'd0, fail_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_en", {31'd0, entry_en}, 32'd1);
        chk("post_rst_state", {29'd0, state_code}, 32'd0);

        // 1: program password
        pulse(8'h1B, 1'b1, 1'b0);
        chk("prog_state", {29'd0, state_code}, 32'd1);
        chk("prog_clr", {31'd0, entry_clr}, 32'd1);
        chk("prog_unl", {31'd0, unlocked}, 32'd0);
        tick();
        chk("prog_clr_drop", {31'd0, entry_clr}, 32'd0);

        // 2: match then mismatch
        pulse(8'h1B, 1'b1, 1'b0);
        chk("match_unl", {31'd0, unlocked}, 32'd1);
        chk("match_state", {29'd0, state_code}, 32'd2);
        chk("match_fail", {28'd0, fail_cnt}, 32'd0);
        chk("unl_en_off", {31'd0, entry_en}, 32'd0);
        pulse(8'h00, 1'b0, 1'b1);
        chk("relock_state", {29'd0, state_code}, 32'd1);
        pulse(8'h1A, 1'b1, 1'b0);
        chk("miss1_fail", {28'd0, fail_cnt}, 32'd1);
        chk("miss1_state", {29'd0, state_code}, 32'd1);

        // 3: reach lockout
        pulse(8'h00, 1'b1, 1'b0);
        chk("miss2_fail", {28'd0, fail_cnt}, 32'd2);
        pulse(8'h00, 1'b1, 1'b0);
        chk("lo_alarm", {31'd0, alarm}, 32'd1);
        chk("lo_state", {29'd0, state_code}, 32'd3);
        chk("lo_en", {31'd0, entry_en}, 32'd0);
        n_alarm = 1;
        n_clr = 0;
        for (int i = 0; i < 12; i++) begin
            seq = 8'h1B;
            seq_valid = (i == 1 || i == 2);
            tick();
            if (alarm) n_alarm++;
            if (entry_clr) n_clr++;
        end
        seq_valid = 1'b0;
        chk("lo_cycles", n_alarm, 32'd8);
        chk("lo_no_clr", n_clr, 32'd0);
        chk("lo_exit_state", {29'd0, state_code}, 32'd1);
        chk("lo_exit_alarm", {31'd0, alarm}, 32'd0);
        chk("lo_exit_fail", {28'd0, fail_cnt}, 32'd0);

        // 4: reprogram while unlocked
        pulse(8'h1B, 1'b1, 1'b0);
        chk("unl2_state", {29'd0, state_code}, 32'd2);
        mode_set = 1'b1;
        tick();
        chk("mode_en", {31'd0, entry_en}, 32'd1);
        pulse(8'hE4, 1'b1, 1'b0);
        chk("reprog_state", {29'd0, state_code}, 32'd2);
        chk("reprog_clr", {31'd0, entry_clr}, 32'd1);
        mode_set = 1'b0;
        pulse(8'h00, 1'b0, 1'b1);
        pulse(8'h1B, 1'b1, 1'b0);
        chk("oldpw_fail", {28'd0, fail_cnt}, 32'd1);
        pulse(8'hE4, 1'b1, 1'b0);
        chk("newpw_unl", {31'd0, unlocked}, 32'd1);
        chk("newpw_fail", {28'd0, fail_cnt}, 32'd0);

        // 5: relock wins over coincident reprogram
        mode_set = 1'b1;
        pulse(8'h55, 1'b1, 1'b1);
        mode_set = 1'b0;
        chk("rl_win_state", {29'd0, state_code}, 32'd1);
        chk("rl_win_clr", {31'd0, entry_clr}, 32'd1);
        pulse(8'hE4, 1'b1, 1'b0);
        chk("rl_pw_kept", {29'd0, state_code}, 32'd2);

        // Sequence without mode_set in UNLOCKED is discarded
        pulse(8'h55, 1'b1, 1'b0);
        chk("disc_state", {29'd0, state_code}, 32'd2);
        chk("disc_clr", {31'd0, entry_clr}, 32'd1);
        repeat (20) tick();
`ifdef AUTO_RELOCK_EN
        chk("idle_unl", {29'd0, state_code}, 32'd1);
        pulse(8'hE4, 1'b1, 1'b0);
`else
        chk("idle_unl", {29'd0, state_code}, 32'd2);
`endif
        pulse(8'h00, 1'b0, 1'b1);
        pulse(8'h55, 1'b1, 1'b0);
        chk("disc_pw_kept", {28'd0, fail_cnt}, 32'd1);

        // 6: reset during lockout
        pulse(8'h00, 1'b1, 1'b0);
        pulse(8'h00, 1'b1, 1'b0);
        chk("lo2_state", {29'd0, state_code}, 32'd3);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {28'd0, entry_en, entry_clr, unlocked, alarm}, 32'd0);
        chk("mid_rst_state", {29'd0, state_code}, 32'd0);
        chk("mid_rst_fail", {28'd0, fail_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        pulse(8'h3C, 1'b1, 1'b0);
        chk("new_pw_state", {29'd0, state_code}, 32'd1);
        pulse(8'h3C, 1'b1, 1'b0);
        chk("new_pw_unl", {29'd0, state_code}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
